updown_mod_counter: RTL and testbench

Parametrised synchronous up/down counter with these features:
- programmable modulus
- clock-enable prescaler
- parallel load
- wrap or saturate mode
- terminal-count and wrap-event flags

It replaces the fixed 4-bit ripple down counters in timer, divider and sequencing logic. All state is clocked on clk only; there are no derived clocks.

---
 rtl/updown_mod_counter_if.sv | 26 ++
 rtl/updown_mod_counter.sv | 94 +++++++++
 tb/tb_updown_mod_counter.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/updown_mod_counter_if.sv
// Control and status bundle for updown_mod_counter.
// The master drives the controls and the slave (the counter) drives the status signals.
interface updown_mod_counter_if #(
  parameter int WIDTH = 4
);
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             up_dn;
  logic             sat_mode;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrap;
  logic             sat_hit;

  modport master (
    output clr, load, load_val, en, up_dn, sat_mode,
    input  count, tc, wrap, sat_hit
  );

  modport slave (
    input  clr, load, load_val, en, up_dn, sat_mode,
    output count, tc, wrap, sat_hit
  );
endinterface

// File: rtl/updown_mod_counter.sv
// Up/down counter with a programmable modulus, an enable prescaler, parallel load,
// wrap or saturate limits, and terminal-count, wrap-pulse and sticky-saturation flags.
module updown_mod_counter #(
  parameter int     WIDTH    = 4,
  parameter longint MODULUS  = 16,
  parameter int     PRESCALE = 1
) (
  input logic                clk,
  input logic                rst,
  updown_mod_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam int               PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] load_clamped;
  logic             wrap_q;
  logic             sat_hit_q;
  logic             at_max;
  logic             at_zero;
  logic             at_limit;
  logic             pre_done;
  logic             step;

  always_comb begin
    at_max       = (count_q == MAX_VAL);
    at_zero      = (count_q == '0);
    at_limit     = bus.up_dn ? at_max : at_zero;
    load_clamped = (bus.load_val > MAX_VAL) ? MAX_VAL : bus.load_val;
    step         = bus.en && !bus.clr && !bus.load && pre_done;
  end

  // The prescaler counts enabled cycles; a step fires on its last phase.
  // With PRESCALE=1 every enabled cycle is a step, so no register exists.
  generate
    if (PRESCALE > 1) begin : g_pre
      localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
      logic [PW-1:0] pre_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pre_q <= '0;
        end else if (bus.clr || bus.load) begin
          pre_q <= '0;
        end else if (bus.en) begin
          if (pre_q == PRE_LAST) begin
            pre_q <= '0;
          end else begin
            pre_q <= pre_q + PW'(1);
          end
        end
      end

      assign pre_done = (pre_q == PRE_LAST);
    end else begin : g_nopre
      assign pre_done = 1'b1;
    end
  endgenerate

  // wrap defaults low every cycle so it can only ever be a one-cycle pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= '0;
      wrap_q    <= 1'b0;
      sat_hit_q <= 1'b0;
    end else if (bus.clr) begin
      count_q   <= '0;
      wrap_q    <= 1'b0;
      sat_hit_q <= 1'b0;
    end else if (bus.load) begin
      count_q <= load_clamped;
      wrap_q  <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (step) begin
        if (!at_limit) begin
          count_q <= bus.up_dn ? (count_q + WIDTH'(1)) : (count_q - WIDTH'(1));
        end else if (!bus.sat_mode) begin
          count_q <= bus.up_dn ? '0 : MAX_VAL;
          wrap_q  <= 1'b1;
        end else begin
          sat_hit_q <= 1'b1;
        end
      end
    end
  end

  assign bus.count   = count_q;
  assign bus.tc      = at_limit;
  assign bus.wrap    = wrap_q;
  assign bus.sat_hit = sat_hit_q;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Scoreboard bench for updown_mod_counter: three configurations share one stimulus
// stream, an arithmetic reference model predicts each edge, a monitor compares.
module tb_updown_mod_counter;

  localparam int N  = 3;
  localparam int W0 = 4, M0 = 10, P0 = 1;
  localparam int W1 = 4, M1 = 16, P1 = 3;
  localparam int W2 = 3, M2 = 8,  P2 = 2;

  typedef struct packed {
    logic [N-1:0][3:0] cnt;
    logic [N-1:0]      wrap;
    logic [N-1:0]      sat;
    logic [N-1:0]      tc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  updown_mod_counter_if #(.WIDTH(W0)) if0 ();
  updown_mod_counter_if #(.WIDTH(W1)) if1 ();
  updown_mod_counter_if #(.WIDTH(W2)) if2 ();

  updown_mod_counter #(.WIDTH(W0), .MODULUS(M0), .PRESCALE(P0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  updown_mod_counter #(.WIDTH(W1), .MODULUS(M1), .PRESCALE(P1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  updown_mod_counter #(.WIDTH(W2), .MODULUS(M2), .PRESCALE(P2)) dut2 (.clk(clk), .rst(rst), .bus(if2));

  int mod_a[N]  = '{M0, M1, M2};
  int pre_a[N]  = '{P0, P1, P2};
  int mask_a[N] = '{(1 << W0) - 1, (1 << W1) - 1, (1 << W2) - 1};

  int m_cnt[N];
  int m_pre[N];
  bit m_wrap[N];
  bit m_sat[N];

  bit s_clr, s_load, s_en, s_up, s_sat;
  int s_lv;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic int act_count(int i);
    case (i)
      0:       return int'(if0.count);
      1:       return int'(if1.count);
      default: return int'(if2.count);
    endcase
  endfunction

  function automatic int act_tc(int i);
    case (i)
      0:       return int'(if0.tc);
      1:       return int'(if1.tc);
      default: return int'(if2.tc);
    endcase
  endfunction

  function automatic int act_wrap(int i);
    case (i)
      0:       return int'(if0.wrap);
      1:       return int'(if1.wrap);
      default: return int'(if2.wrap);
    endcase
  endfunction

  function automatic int act_sat(int i);
    case (i)
      0:       return int'(if0.sat_hit);
      1:       return int'(if1.sat_hit);
      default: return int'(if2.sat_hit);
    endcase
  endfunction

  function automatic bit model_tc(int i);
    return s_up ? (m_cnt[i] == mod_a[i] - 1) : (m_cnt[i] == 0);
  endfunction

  task automatic checkOutput(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s[%0d] at %0t: got %0d expected %0d", name, idx, $time, act, exp);
    end
  endtask

  task automatic driveAll();
    if0.clr = s_clr; if0.load = s_load; if0.load_val = W0'(s_lv);
    if0.en  = s_en;  if0.up_dn = s_up;  if0.sat_mode = s_sat;
    if1.clr = s_clr; if1.load = s_load; if1.load_val = W1'(s_lv);
    if1.en  = s_en;  if1.up_dn = s_up;  if1.sat_mode = s_sat;
    if2.clr = s_clr; if2.load = s_load; if2.load_val = W2'(s_lv);
    if2.en  = s_en;  if2.up_dn = s_up;  if2.sat_mode = s_sat;
  endtask

  // Reference: count lives in [0, mod); a step that would leave the range either
  // folds back modulo mod (wrap) or is refused (saturate).
  task automatic modelEdge(input bit r);
    for (int i = 0; i < N; i++) begin
      if (r || s_clr) begin
        m_cnt[i] = 0; m_pre[i] = 0; m_wrap[i] = 0; m_sat[i] = 0;
      end else if (s_load) begin
        int lv;
        lv = s_lv & mask_a[i];
        m_cnt[i]  = (lv < mod_a[i]) ? lv : mod_a[i] - 1;
        m_pre[i]  = 0;
        m_wrap[i] = 0;
      end else begin
        m_wrap[i] = 0;
        if (s_en) begin
          m_pre[i]++;
          if (m_pre[i] == pre_a[i]) begin
            int nxt;
            m_pre[i] = 0;
            nxt = m_cnt[i] + (s_up ? 1 : -1);
            if (nxt >= 0 && nxt < mod_a[i]) begin
              m_cnt[i] = nxt;
            end else if (s_sat) begin
              m_sat[i] = 1;
            end else begin
              m_cnt[i]  = (nxt + mod_a[i]) % mod_a[i];
              m_wrap[i] = 1;
            end
          end
        end
      end
    end
  endtask

  task automatic pushExpect();
    exp_t e;
    for (int i = 0; i < N; i++) begin
      e.cnt[i]  = 4'(m_cnt[i]);
      e.wrap[i] = m_wrap[i];
      e.sat[i]  = m_sat[i];
      e.tc[i]   = model_tc(i);
    end
    q.push_back(e);
  endtask

  task automatic applyStimulus(input bit r, input bit c, input bit l, input int lv,
                               input bit e, input bit u, input bit s);
    @(negedge clk);
    s_clr = c; s_load = l; s_lv = lv; s_en = e; s_up = u; s_sat = s;
    rst = r;
    driveAll();
    #1;
    if (!r) begin
      for (int i = 0; i < N; i++) checkOutput("tc_same_cycle", i, act_tc(i), int'(model_tc(i)));
    end
    modelEdge(r);
    pushExpect();
  endtask

  // Reset raised between edges must clear the count before the next edge arrives.
  task automatic asyncReset();
    @(negedge clk);
    s_clr = 0; s_load = 0; s_en = 1;
    driveAll();
    #2;
    rst = 1'b1;
    #1;
    for (int i = 0; i < N; i++) begin
      checkOutput("async_rst_count", i, act_count(i), 0);
      checkOutput("async_rst_wrap", i, act_wrap(i), 0);
    end
    modelEdge(1'b1);
    pushExpect();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        for (int i = 0; i < N; i++) begin
          checkOutput("count", i, act_count(i), int'(e.cnt[i]));
          checkOutput("wrap", i, act_wrap(i), int'(e.wrap[i]));
          checkOutput("sat_hit", i, act_sat(i), int'(e.sat[i]));
          checkOutput("tc", i, act_tc(i), int'(e.tc[i]));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    int r_rst, r_clr, r_load;
    s_clr = 0; s_load = 0; s_lv = 0; s_en = 0; s_up = 1; s_sat = 0;
    driveAll();
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 0; m_pre[i] = 0; m_wrap[i] = 0; m_sat[i] = 0;
    end

    applyStimulus(1, 0, 0, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 12; k++) applyStimulus(0, 0, 0, 0, 1, 1, 0);

    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 0, 1, 0, 0);
    asyncReset();

    applyStimulus(0, 0, 1, 8, 0, 1, 1);
    for (int k = 0; k < 9; k++) applyStimulus(0, 0, 0, 0, 1, 1, 1);
    applyStimulus(0, 1, 0, 0, 1, 1, 1);

    for (int k = 1; k <= 9; k++) applyStimulus(0, 0, 0, 0, (k != 4), 1, 0);

    applyStimulus(0, 0, 1, 13, 0, 1, 0);
    applyStimulus(0, 1, 1, 13, 1, 1, 0);
    applyStimulus(0, 0, 1, 5, 1, 1, 0);

    applyStimulus(0, 0, 1, 9, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 0, 1, 0, 0);

    for (int k = 0; k < 500; k++) begin
      r_rst  = ($urandom_range(0, 99) == 0);
      r_clr  = ($urandom_range(0, 39) == 0);
      r_load = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0) s_up = ~s_up;
      if ($urandom_range(0, 19) == 0) s_sat = ~s_sat;
      applyStimulus(bit'(r_rst), bit'(r_clr), bit'(r_load), int'($urandom_range(0, 15)),
                    ($urandom_range(0, 3) != 0), s_up, s_sat);
    end

    repeat (3) @(negedge clk);
    checkOutput("queue_drain", 0, q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
